// File: rtl/matmul_lane_array.sv
// rtl/matmul_lane_array.sv - parametrised ROWS-lane MAC array with tile framing and result handshake
// Each lane accumulates its activation times a broadcast weight over a tile of up to K_MAX beats.
// The finished tile is copied into a result buffer so the next tile can start while it is held.
module matmul_lane_array #(
  parameter int ROWS  = 8,
  parameter int DW    = 8,
  parameter int AW    = 32,
  parameter int K_MAX = 16,
  parameter int SAT   = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  output logic                         in_ready_o,
  input  logic                         last_i,
  input  logic                         signed_i,
  input  logic [ROWS*DW-1:0]           din1_i,
  input  logic [DW-1:0]                din2_i,
  output logic                         done_o,
  input  logic                         out_ready_i,
  output logic [ROWS*AW-1:0]           matmul_o,
  output logic [$clog2(K_MAX+1)-1:0]   beats_o,
  output logic                         err_o
);

  localparam int CW = $clog2(K_MAX+1);
  localparam logic [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_MAX = CW'(K_MAX);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state_q, state_d;
  logic [ROWS*AW-1:0] acc_q;
  logic [ROWS*AW-1:0] sum_vec;
  logic [CW-1:0]      cnt_q, cnt_nxt;
  logic               mode_q, mode_eff;
  logic               accept, publish;

  assign in_ready_o = ~done_o | out_ready_i;
  assign accept     = en_i & in_ready_o;
  // The first beat of a tile uses the live mode input; later beats use the latched one.
  assign mode_eff   = (state_q == IDLE) ? signed_i : mode_q;

  // Per-lane product and accumulate, with optional clamping on overflow
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DW-1:0] a;
    logic [AW-1:0] ea, eb, prod, base, res;
    logic [AW:0]   s;

    assign a = din1_i[r*DW +: DW];

    // Extend both operands to AW bits first so the truncated product is exact in either mode
    always_comb begin
      ea   = {{(AW-DW){1'b0}}, a};
      eb   = {{(AW-DW){1'b0}}, din2_i};
      if (mode_eff) begin
        ea = {{(AW-DW){a[DW-1]}}, a};
        eb = {{(AW-DW){din2_i[DW-1]}}, din2_i};
      end
      prod = ea * eb;
      base = (state_q == ACCUM) ? acc_q[r*AW +: AW] : '0;
      s    = {1'b0, base} + {1'b0, prod};
      res  = s[AW-1:0];
      if (SAT != 0) begin
        if (mode_eff) begin
          if ((base[AW-1] == prod[AW-1]) && (s[AW-1] != base[AW-1]))
            res = base[AW-1] ? SMIN : SMAX;
        end else if (s[AW]) begin
          res = '1;
        end
      end
    end

    assign sum_vec[r*AW +: AW] = res;
  end

  // Beat count including the current beat; pinned at K_MAX once the tile runs long
  always_comb begin
    cnt_nxt = CW'(1);
    if (state_q == ACCUM)
      cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  end

  // Next-state logic: a tile is open from its first accepted beat until the beat flagged last
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (last_i) publish = 1'b1;
          else        state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && last_i) begin
          publish = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Accumulators, beat counter, latched mode and sticky overrun flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      err_o  <= 1'b0;
    end else if (accept) begin
      acc_q <= sum_vec;
      cnt_q <= cnt_nxt;
      if (state_q == IDLE) mode_q <= signed_i;
      if ((state_q == ACCUM) && (cnt_q == CNT_MAX)) err_o <= 1'b1;
    end
  end

  // Result buffer: load on publish, otherwise release valid once the consumer takes it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      matmul_o <= '0;
      beats_o  <= '0;
      done_o   <= 1'b0;
    end else if (publish) begin
      matmul_o <= sum_vec;
      beats_o  <= cnt_nxt;
      done_o   <= 1'b1;
    end else if (done_o && out_ready_i) begin
      done_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_lane_array.sv
// tb/tb_matmul_lane_array.sv - directed self-checking bench for matmul_lane_array
module tb_matmul_lane_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        last = 1'b0;
  logic        sgn = 1'b0;
  logic [63:0] din1 = '0;
  logic [7:0]  din2 = '0;
  logic        out_ready = 1'b1;

  logic         m_rdy, m_done, m_err;
  logic [255:0] m_res;
  logic [4:0]   m_beats;
  logic         w_rdy, w_done, w_err;
  logic [127:0] w_res;
  logic [4:0]   w_beats;
  logic         s_rdy, s_done, s_err;
  logic [127:0] s_res;
  logic [4:0]   s_beats;
  logic         k_rdy, k_done, k_err;
  logic [255:0] k_res;
  logic [2:0]   k_beats;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  matmul_lane_array #(.ROWS(8), .DW(8), .AW(32), .K_MAX(16), .SAT(0)) u_main (
    .clk_i(clk), .rst_i(rst), .en_i(en), .in_ready_o(m_rdy), .last_i(last), .signed_i(sgn),
    .din1_i(din1), .din2_i(din2), .done_o(m_done), .out_ready_i(out_ready),
    .matmul_o(m_res), .beats_o(m_beats), .err_o(m_err));

  matmul_lane_array #(.ROWS(8), .DW(8), .AW(16), .K_MAX(16), .SAT(0)) u_w16 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .in_ready_o(w_rdy), .last_i(last), .signed_i(sgn),
    .din1_i(din1), .din2_i(din2), .done_o(w_done), .out_ready_i(out_ready),
    .matmul_o(w_res), .beats_o(w_beats), .err_o(w_err));

  matmul_lane_array #(.ROWS(8), .DW(8), .AW(16), .K_MAX(16), .SAT(1)) u_s16 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .in_ready_o(s_rdy), .last_i(last), .signed_i(sgn),
    .din1_i(din1), .din2_i(din2), .done_o(s_done), .out_ready_i(out_ready),
    .matmul_o(s_res), .beats_o(s_beats), .err_o(s_err));

  matmul_lane_array #(.ROWS(8), .DW(8), .AW(32), .K_MAX(4), .SAT(0)) u_k4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .in_ready_o(k_rdy), .last_i(last), .signed_i(sgn),
    .din1_i(din1), .din2_i(din2), .done_o(k_done), .out_ready_i(out_ready),
    .matmul_o(k_res), .beats_o(k_beats), .err_o(k_err));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d1, input logic [7:0] w, input logic l, input logic s);
    @(negedge clk);
    din1 = d1; din2 = w; last = l; sgn = s; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (m_done !== 1'b0) $display("FAIL reset_done got %0b want 0", m_done); else n_pass++;
    n_total++;
    if (m_res !== 256'h0) $display("FAIL reset_matmul got %h want 0", m_res); else n_pass++;
    n_total++;
    if (m_beats !== 5'd0) $display("FAIL reset_beats got %0d want 0", m_beats); else n_pass++;
    n_total++;
    if (m_err !== 1'b0) $display("FAIL reset_err got %0b want 0", m_err); else n_pass++;
    n_total++;
    if (m_rdy !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", m_rdy); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    beat({8'h01, 48'h0, 8'h01}, 8'd1, 1'b0, 1'b0);
    beat({8'h02, 48'h0, 8'h01}, 8'd1, 1'b0, 1'b0);
    beat({8'h03, 48'h0, 8'h01}, 8'd2, 1'b0, 1'b0);
    n_total++;
    if (m_done !== 1'b0) $display("FAIL basic_not_done_early got %0b want 0", m_done); else n_pass++;
    beat({8'h01, 48'h0, 8'h02}, 8'd1, 1'b1, 1'b0);
    n_total++;
    if (m_done !== 1'b1) $display("FAIL basic_done got %0b want 1", m_done); else n_pass++;
    n_total++;
    if (m_res[31:0] !== 32'd6) $display("FAIL basic_lane0 got %0d want 6", m_res[31:0]); else n_pass++;
    n_total++;
    if (m_res[255:224] !== 32'd10) $display("FAIL basic_lane7 got %0d want 10", m_res[255:224]); else n_pass++;
    n_total++;
    if (m_res[63:32] !== 32'd0) $display("FAIL basic_lane1 got %0d want 0", m_res[63:32]); else n_pass++;
    n_total++;
    if (m_beats !== 5'd4) $display("FAIL basic_beats got %0d want 4", m_beats); else n_pass++;
  endtask

  task automatic test_signed();
    do_reset();
    beat(64'hFF, 8'h02, 1'b1, 1'b1);
    n_total++;
    if (m_res[31:0] !== 32'hFFFFFFFE) $display("FAIL signed_lane0 got %h want FFFFFFFE", m_res[31:0]); else n_pass++;
    beat(64'hFF, 8'h02, 1'b1, 1'b0);
    n_total++;
    if (m_done !== 1'b1) $display("FAIL b2b_done_held got %0b want 1", m_done); else n_pass++;
    n_total++;
    if (m_res[31:0] !== 32'h000001FE) $display("FAIL unsigned_lane0 got %h want 000001FE", m_res[31:0]); else n_pass++;
    beat(64'hFF, 8'h01, 1'b0, 1'b1);
    beat(64'hFF, 8'h01, 1'b1, 1'b0);
    n_total++;
    if (m_res[31:0] !== 32'hFFFFFFFE) $display("FAIL mode_latched got %h want FFFFFFFE", m_res[31:0]); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk); out_ready = 1'b0;
    beat(64'h03, 8'd4, 1'b1, 1'b0);
    n_total++;
    if (m_res[31:0] !== 32'd12) $display("FAIL stall_first got %0d want 12", m_res[31:0]); else n_pass++;
    n_total++;
    if (m_rdy !== 1'b0) $display("FAIL stall_in_ready got %0b want 0", m_rdy); else n_pass++;
    beat(64'h05, 8'd5, 1'b0, 1'b0);
    beat(64'h05, 8'd5, 1'b1, 1'b0);
    n_total++;
    if (m_res[31:0] !== 32'd12) $display("FAIL stall_hold got %0d want 12", m_res[31:0]); else n_pass++;
    n_total++;
    if (m_done !== 1'b1 || m_beats !== 5'd1)
      $display("FAIL stall_done_beats got done=%0b beats=%0d want done=1 beats=1", m_done, m_beats);
    else n_pass++;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (m_done !== 1'b0) $display("FAIL stall_release got %0b want 0", m_done); else n_pass++;
    n_total++;
    if (m_res[31:0] !== 32'd12) $display("FAIL stall_after_release got %0d want 12", m_res[31:0]); else n_pass++;
    beat(64'h02, 8'd3, 1'b1, 1'b0);
    n_total++;
    if (m_done !== 1'b1 || m_res[31:0] !== 32'd6)
      $display("FAIL stall_second got done=%0b lane0=%0d want done=1 lane0=6", m_done, m_res[31:0]);
    else n_pass++;
  endtask

  task automatic test_sat();
    do_reset();
    beat(64'hFF, 8'hFF, 1'b0, 1'b0);
    beat(64'hFF, 8'hFF, 1'b1, 1'b0);
    n_total++;
    if (w_res[15:0] !== 16'hFC02) $display("FAIL wrap_u16 got %h want FC02", w_res[15:0]); else n_pass++;
    n_total++;
    if (s_res[15:0] !== 16'hFFFF) $display("FAIL sat_u16 got %h want FFFF", s_res[15:0]); else n_pass++;
    n_total++;
    if (m_res[31:0] !== 32'h0001FC02) $display("FAIL wide_u32 got %h want 0001FC02", m_res[31:0]); else n_pass++;
    for (int i = 0; i < 5; i++) beat(64'h7F, 8'h7F, (i == 4), 1'b1);
    n_total++;
    if (s_res[15:0] !== 16'h7FFF) $display("FAIL sat_s16_max got %h want 7FFF", s_res[15:0]); else n_pass++;
    n_total++;
    if (w_res[15:0] !== 16'h3B05) $display("FAIL wrap_s16 got %h want 3B05", w_res[15:0]); else n_pass++;
    for (int i = 0; i < 3; i++) beat(64'h80, 8'h7F, (i == 2), 1'b1);
    n_total++;
    if (s_res[15:0] !== 16'h8000) $display("FAIL sat_s16_min got %h want 8000", s_res[15:0]); else n_pass++;
    n_total++;
    if (w_res[15:0] !== 16'h4180) $display("FAIL wrap_s16_neg got %h want 4180", w_res[15:0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    beat(64'h07, 8'd7, 1'b1, 1'b0);
    n_total++;
    if (m_res[31:0] !== 32'd49) $display("FAIL rstmid_pre got %0d want 49", m_res[31:0]); else n_pass++;
    beat(64'h03, 8'd3, 1'b0, 1'b0);
    beat(64'h03, 8'd3, 1'b0, 1'b0);
    do_reset();
    n_total++;
    if (m_done !== 1'b0 || m_res !== 256'h0)
      $display("FAIL rstmid_clear got done=%0b lane0=%0d want done=0 lane0=0", m_done, m_res[31:0]);
    else n_pass++;
    beat(64'h02, 8'd5, 1'b1, 1'b0);
    n_total++;
    if (m_res[31:0] !== 32'd10 || m_beats !== 5'd1)
      $display("FAIL rstmid_fresh got lane0=%0d beats=%0d want lane0=10 beats=1", m_res[31:0], m_beats);
    else n_pass++;
  endtask

  task automatic test_kmax();
    do_reset();
    for (int i = 0; i < 4; i++) beat(64'h01, 8'd1, 1'b0, 1'b0);
    n_total++;
    if (k_err !== 1'b0) $display("FAIL kmax_err_early got %0b want 0", k_err); else n_pass++;
    beat(64'h01, 8'd1, 1'b1, 1'b0);
    n_total++;
    if (k_err !== 1'b1) $display("FAIL kmax_err got %0b want 1", k_err); else n_pass++;
    n_total++;
    if (k_beats !== 3'd4) $display("FAIL kmax_beats got %0d want 4", k_beats); else n_pass++;
    n_total++;
    if (m_err !== 1'b0 || m_beats !== 5'd5)
      $display("FAIL k16_no_err got err=%0b beats=%0d want err=0 beats=5", m_err, m_beats);
    else n_pass++;
    beat(64'h01, 8'd1, 1'b1, 1'b0);
    n_total++;
    if (k_err !== 1'b1) $display("FAIL kmax_sticky got %0b want 1", k_err); else n_pass++;
    do_reset();
    n_total++;
    if (k_err !== 1'b0) $display("FAIL kmax_rst_clear got %0b want 0", k_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_sat();
    test_reset_mid();
    test_kmax();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
